// File: rtl/iq_upsampler_param.sv
// iq_upsampler_param: I/Q upsampler emitting FACTOR samples per symbol, zero-stuffed or held, valid/ready both sides.
module iq_upsampler_param #(
  parameter int DATA_W     = 4,
  parameter int MAX_FACTOR = 16,
  parameter int FACTOR_W   = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [FACTOR_W-1:0]        cfg_factor,
  input  logic                       cfg_mode,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [DATA_W-1:0]   in_i,
  input  logic signed [DATA_W-1:0]   in_q,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [DATA_W-1:0]   out_i,
  output logic signed [DATA_W-1:0]   out_q,
  output logic                       out_first,
  output logic [FACTOR_W-1:0]        out_phase
);
  typedef enum logic {IDLE, EMIT} state_t;
  localparam logic [FACTOR_W-1:0] MAXF = FACTOR_W'(MAX_FACTOR);
  state_t                    state_q;
  logic                      en_q;
  logic signed [DATA_W-1:0]  sym_i_q, sym_q_q;
  logic [FACTOR_W-1:0]       fact_q, phase_q, fact_d;
  logic                      mode_q, last, accept, show;
  always_comb begin
    fact_d   = cfg_factor < FACTOR_W'(2) ? FACTOR_W'(1) : cfg_factor > MAXF ? MAXF : cfg_factor;
    last     = phase_q == fact_q - FACTOR_W'(1);
    in_ready = en_q & ((state_q == IDLE) | (out_ready & last));
    accept   = in_valid & in_ready;
  end
  // en_q holds off in_ready until the first edge after reset release
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      en_q    <= 1'b0;
      sym_i_q <= '0;
      sym_q_q <= '0;
      fact_q  <= '0;
      mode_q  <= 1'b0;
      phase_q <= '0;
    end else begin
      en_q <= 1'b1;
      if (accept) begin
        state_q <= EMIT;
        sym_i_q <= in_i;
        sym_q_q <= in_q;
        fact_q  <= fact_d;
        mode_q  <= cfg_mode;
        phase_q <= '0;
      end else if (state_q == EMIT && out_ready) begin
        if (last) begin
          state_q <= IDLE;
          phase_q <= '0;
        end else begin
          phase_q <= phase_q + FACTOR_W'(1);
        end
      end
    end
  end
  always_comb begin
    out_valid = state_q == EMIT;
    show      = out_valid & ((phase_q == '0) | mode_q);
    out_i     = show ? sym_i_q : '0;
    out_q     = show ? sym_q_q : '0;
    out_first = out_valid & (phase_q == '0);
    out_phase = phase_q;
  end
endmodule

// File: tb/tb_iq_upsampler_param.sv
// tb_iq_upsampler_param: directed checks of reset, zero-stuff/hold, stalls, factor clamp and mid-symbol reset.
module tb_iq_upsampler_param;
  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [4:0]        cfg_factor = '0;
  logic              cfg_mode = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic signed [3:0] in_i = '0, in_q = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic signed [3:0] out_i, out_q;
  logic              out_first;
  logic [4:0]        out_phase;
  int total = 0, bad = 0;

  iq_upsampler_param #(.DATA_W(4), .MAX_FACTOR(16), .FACTOR_W(5)) dut (
    .clk(clk), .reset(reset), .cfg_factor(cfg_factor), .cfg_mode(cfg_mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_i(in_i), .in_q(in_q),
    .out_valid(out_valid), .out_ready(out_ready), .out_i(out_i), .out_q(out_q),
    .out_first(out_first), .out_phase(out_phase)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int v, input int i, input int q, input int f, input int p);
    chk({tag, ".valid"}, int'(out_valid), v);
    chk({tag, ".i"}, int'(out_i), i);
    chk({tag, ".q"}, int'(out_q), q);
    chk({tag, ".first"}, int'(out_first), f);
    chk({tag, ".phase"}, int'(out_phase), p);
  endtask

  task automatic send(input int f, input bit m, input int i, input int q);
    cfg_factor = 5'(f);
    cfg_mode   = m;
    in_i       = 4'(i);
    in_q       = 4'(q);
    in_valid   = 1'b1;
  endtask

  initial begin
    int n;
    // 1: reset
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk_out("rst", 0, 0, 0, 0, 0);
    chk("rst.ready", int'(in_ready), 0);
    reset = 1'b1;
    #1 chk("rel.ready0", int'(in_ready), 0);
    @(negedge clk);
    chk("rel.ready1", int'(in_ready), 1);
    chk_out("rel", 0, 0, 0, 0, 0);
    // 2: factor 4 zero-stuff
    send(4, 1'b0, 3, -1);
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk_out($sformatf("zs%0d", k), 1, k == 0 ? 3 : 0, k == 0 ? -1 : 0, k == 0 ? 1 : 0, k);
      @(negedge clk);
    end
    chk("zs.end", int'(out_valid), 0);
    // 3: factor 4 hold, back-to-back symbols
    send(4, 1'b1, 3, -1);
    @(negedge clk);
    send(4, 1'b1, -3, 1);
    for (int k = 0; k < 8; k++) begin
      #1;
      chk_out($sformatf("sh%0d", k), 1, k < 4 ? 3 : -3, k < 4 ? -1 : 1, (k % 4) == 0 ? 1 : 0, k % 4);
      chk($sformatf("sh%0d.ready", k), int'(in_ready), (k % 4) == 3 ? 1 : 0);
      @(negedge clk);
      if (k == 3) in_valid = 1'b0;
    end
    chk("sh.end", int'(out_valid), 0);
    // 4: stall at phase 2 with next symbol waiting
    send(4, 1'b1, 5, -2);
    @(negedge clk);
    send(4, 1'b1, -6, 7);
    repeat (2) @(negedge clk);
    chk_out("st.p2", 1, 5, -2, 0, 2);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk_out($sformatf("st.hold%0d", k), 1, 5, -2, 0, 2);
      chk($sformatf("st.hold%0d.ready", k), int'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk_out("st.p3", 1, 5, -2, 0, 3);
    #1 chk("st.p3.ready", int'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk_out("st.next", 1, -6, 7, 1, 0);
    repeat (4) @(negedge clk);
    chk("st.end", int'(out_valid), 0);
    // 5: factor clamp low then high, mid-symbol cfg change ignored
    send(0, 1'b0, 1, 2);
    @(negedge clk);
    chk_out("f1", 1, 1, 2, 1, 0);
    send(31, 1'b1, 2, 3);
    #1 chk("f1.ready", int'(in_ready), 1);
    @(negedge clk);
    in_valid   = 1'b0;
    cfg_factor = 5'd2;
    cfg_mode   = 1'b0;
    chk_out("f16.p0", 1, 2, 3, 1, 0);
    n = 0;
    for (int k = 0; k < 40 && out_valid; k++) begin
      if (k == 15) chk_out("f16.p15", 1, 2, 3, 0, 15);
      n++;
      @(negedge clk);
    end
    chk("f16.count", n, 16);
    // 6: reset at phase 5 of factor 8
    send(8, 1'b0, 4, -4);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk_out("mr.p5", 1, 0, 0, 0, 5);
    reset = 1'b0;
    #1 chk_out("mr.rst", 0, 0, 0, 0, 0);
    chk("mr.rst.ready", int'(in_ready), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mr.rel.ready", int'(in_ready), 1);
    chk_out("mr.rel", 0, 0, 0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running want done");
    $fatal(1);
  end
endmodule
